// File: rtl/execute.sv
`default_nettype none
// ============================================================================
//  Module   : execute
//  Purpose  : EX stage of a five-stage MIPS-style pipeline. Computes the
//             branch target, selects the destination register, decodes the
//             ALU operation, runs a 32-bit ALU and holds the EX/MEM pipeline
//             register. Results reach MEM one clock after operands arrive.
//  Ports    :
//    clk, rst_n        - clock (rising edge), async active-low reset
//    wb_ctl, m_ctl     - write-back / memory control, passed through
//    regdst, alusrc    - destination register / operand-B selects
//    aluop, funct      - ALU operation class and R-type function field
//    npcout            - PC+4 of the instruction
//    rdata1, rdata2    - register operands A and B (B is also store data)
//    s_extendout       - sign-extended immediate
//    instrout_2016/1511- rt / rd register numbers
//    wb_ctlout, branch, memread, memwrite, EX_MEM_NPC, zero, alu_result,
//    rdata2out, five_bit_muxout - registered EX/MEM outputs
//  Revision : 1.0 - initial release
// ============================================================================
module execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npcout,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extendout,
  input  logic [4:0]  instrout_2016,
  input  logic [4:0]  instrout_1511,
  input  logic [5:0]  funct,
  output logic [1:0]  wb_ctlout,
  output logic        branch,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] EX_MEM_NPC,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  five_bit_muxout
);

  // ALU select encodings
  localparam logic [2:0] C_SEL_AND = 3'b000;
  localparam logic [2:0] C_SEL_OR  = 3'b001;
  localparam logic [2:0] C_SEL_ADD = 3'b010;
  localparam logic [2:0] C_SEL_NOP = 3'b011;
  localparam logic [2:0] C_SEL_SUB = 3'b110;
  localparam logic [2:0] C_SEL_SLT = 3'b111;

  logic [31:0] w_branch_target;
  logic [31:0] w_operand_b;
  logic [4:0]  w_dest_reg;
  logic [2:0]  w_alu_sel;
  logic [31:0] w_alu_out;
  logic        w_slt;

  // Word offset to byte offset; the sum wraps silently.
  assign w_branch_target = npcout + {s_extendout[29:0], 2'b00};
  assign w_operand_b     = alusrc ? s_extendout : rdata2;
  assign w_dest_reg      = regdst ? instrout_1511 : instrout_2016;
  assign w_slt           = $signed(rdata1) < $signed(w_operand_b);

  // ALU control: loads/stores add, branches subtract, R-type uses funct.
  always_comb begin
    w_alu_sel = C_SEL_NOP;
    if (aluop[1]) begin
      case (funct)
        6'b100000: w_alu_sel = C_SEL_ADD;
        6'b100010: w_alu_sel = C_SEL_SUB;
        6'b100100: w_alu_sel = C_SEL_AND;
        6'b100101: w_alu_sel = C_SEL_OR;
        6'b101010: w_alu_sel = C_SEL_SLT;
        default:   w_alu_sel = C_SEL_NOP;
      endcase
    end else if (aluop[0]) begin
      w_alu_sel = C_SEL_SUB;
    end else begin
      w_alu_sel = C_SEL_ADD;
    end
  end

  always_comb begin
    w_alu_out = 32'd0;
    case (w_alu_sel)
      C_SEL_AND: w_alu_out = rdata1 & w_operand_b;
      C_SEL_OR:  w_alu_out = rdata1 | w_operand_b;
      C_SEL_ADD: w_alu_out = rdata1 + w_operand_b;
      C_SEL_SUB: w_alu_out = rdata1 - w_operand_b;
      C_SEL_SLT: w_alu_out = {31'd0, w_slt};
      default:   w_alu_out = 32'd0;
    endcase
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout       <= 2'd0;
      branch          <= 1'b0;
      memread         <= 1'b0;
      memwrite        <= 1'b0;
      EX_MEM_NPC      <= 32'd0;
      zero            <= 1'b0;
      alu_result      <= 32'd0;
      rdata2out       <= 32'd0;
      five_bit_muxout <= 5'd0;
    end else begin
      wb_ctlout       <= wb_ctl;
      branch          <= m_ctl[2];
      memread         <= m_ctl[1];
      memwrite        <= m_ctl[0];
      EX_MEM_NPC      <= w_branch_target;
      zero            <= (w_alu_out == 32'd0);
      alu_result      <= w_alu_out;
      // Store data is always the register operand, never the immediate.
      rdata2out       <= rdata2;
      five_bit_muxout <= w_dest_reg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute
//  Purpose  : Self-checking bench for the execute stage: directed steps from
//             the test plan plus randomized instructions against a reference
//             model computed from the instruction semantics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  wb_ctl = '0;
  logic [2:0]  m_ctl = '0;
  logic        regdst = 1'b0;
  logic        alusrc = 1'b0;
  logic [1:0]  aluop = '0;
  logic [31:0] npcout = '0;
  logic [31:0] rdata1 = '0;
  logic [31:0] rdata2 = '0;
  logic [31:0] s_extendout = '0;
  logic [4:0]  instrout_2016 = '0;
  logic [4:0]  instrout_1511 = '0;
  logic [5:0]  funct = '0;

  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs
  logic [1:0]  e_wb;
  logic        e_br, e_mr, e_mw, e_zero;
  logic [31:0] e_npc, e_res, e_rd2;
  logic [4:0]  e_dst;

  execute dut (
    .clk(clk), .rst_n(rst_n), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npcout(npcout),
    .rdata1(rdata1), .rdata2(rdata2), .s_extendout(s_extendout),
    .instrout_2016(instrout_2016), .instrout_1511(instrout_1511),
    .funct(funct), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout)
  );

  always #5 clk = ~clk;

  // Reference: what the instruction means, not how the hardware decodes it.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd0) return a + b;   // load/store address
    if (op == 2'd1) return a - b;   // branch compare
    case (f)
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model;
    logic [31:0] b;
    b      = alusrc ? s_extendout : rdata2;
    e_res  = ref_alu(aluop, funct, rdata1, b);
    e_zero = (e_res == 0);
    e_npc  = npcout + s_extendout * 32'd4;
    e_wb   = wb_ctl;
    e_br   = m_ctl[2];
    e_mr   = m_ctl[1];
    e_mw   = m_ctl[0];
    e_rd2  = rdata2;
    e_dst  = regdst ? instrout_1511 : instrout_2016;
  endtask

  task automatic check(input string tag, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check(tag, "wb_ctlout", {30'd0, wb_ctlout}, {30'd0, e_wb});
    check(tag, "branch", {31'd0, branch}, {31'd0, e_br});
    check(tag, "memread", {31'd0, memread}, {31'd0, e_mr});
    check(tag, "memwrite", {31'd0, memwrite}, {31'd0, e_mw});
    check(tag, "npc", EX_MEM_NPC, e_npc);
    check(tag, "zero", {31'd0, zero}, {31'd0, e_zero});
    check(tag, "alu_result", alu_result, e_res);
    check(tag, "rdata2out", rdata2out, e_rd2);
    check(tag, "dst", {27'd0, five_bit_muxout}, {27'd0, e_dst});
  endtask

  task automatic expect_zero(input string tag);
    e_wb = '0; e_br = 0; e_mr = 0; e_mw = 0; e_npc = '0;
    e_zero = 0; e_res = '0; e_rd2 = '0; e_dst = '0;
    check_all(tag);
  endtask

  // Inputs must already be set (at a negedge); capture one edge and compare.
  task automatic step(input string tag);
    model();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs;
    logic [5:0] fl[6];
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    wb_ctl        = 2'($urandom);
    m_ctl         = 3'($urandom);
    regdst        = 1'($urandom);
    alusrc        = 1'($urandom);
    aluop         = 2'($urandom);
    npcout        = $urandom;
    rdata1        = $urandom;
    rdata2        = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom;
    s_extendout   = $urandom_range(0, 1) ? 32'($signed(16'($urandom))) : $urandom;
    instrout_2016 = 5'($urandom);
    instrout_1511 = 5'($urandom);
    funct         = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)];
  endtask

  initial begin
    // Reset with nonzero inputs: outputs must stay 0 across clock edges.
    wb_ctl = 2'b11; m_ctl = 3'b111; regdst = 1; alusrc = 0; aluop = 2'b10;
    npcout = 32'h100; rdata1 = 32'h55; rdata2 = 32'h66; s_extendout = 32'h4;
    instrout_2016 = 5'd7; instrout_1511 = 5'd9; funct = 6'd32;
    #2 rst_n = 0;
    #1 expect_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 expect_zero("reset_held");

    // R-type add, loaded on the first edge after release
    @(negedge clk);
    rst_n = 1;
    wb_ctl = 2'b10; m_ctl = 3'b000; regdst = 1; alusrc = 0; aluop = 2'b10;
    funct = 6'b100000; rdata1 = 10; rdata2 = 20; npcout = 100; s_extendout = 4;
    instrout_2016 = 5; instrout_1511 = 10;
    step("radd");
    check("radd_lit", "alu_result", alu_result, 32'd30);
    check("radd_lit", "npc", EX_MEM_NPC, 32'd116);
    check("radd_lit", "dst", {27'd0, five_bit_muxout}, 32'd10);

    // Inputs changing between edges must not disturb outputs
    #2 rdata1 = 32'hDEAD; funct = 6'd34; regdst = 0;
    #1 check_all("hold");

    @(negedge clk);
    rdata1 = 30; rdata2 = 10; funct = 6'b100010; regdst = 1;
    step("rsub");
    check("rsub_lit", "alu_result", alu_result, 32'd20);

    // beq compare
    @(negedge clk);
    regdst = 0; aluop = 2'b01; m_ctl = 3'b100; rdata1 = 15; rdata2 = 15;
    s_extendout = 8; npcout = 100;
    step("beq");
    check("beq_lit", "zero", {31'd0, zero}, 32'd1);
    check("beq_lit", "npc", EX_MEM_NPC, 32'd132);
    check("beq_lit", "branch", {31'd0, branch}, 32'd1);

    // load address: operand B is the immediate, store data still rdata2
    @(negedge clk);
    regdst = 0; alusrc = 1; aluop = 2'b00; m_ctl = 3'b010; rdata1 = 100;
    s_extendout = 16; rdata2 = 32'h1234;
    step("lw");
    check("lw_lit", "alu_result", alu_result, 32'd116);
    check("lw_lit", "npc", EX_MEM_NPC, 32'd164);
    check("lw_lit", "rdata2out", rdata2out, 32'h1234);

    // Logic, SLT (signed) and NOP
    alusrc = 0; aluop = 2'b10; m_ctl = 3'b000; rdata1 = 32'hFFFF_FFFF; rdata2 = 1;
    @(negedge clk); funct = 6'b100100; step("and");
    check("and_lit", "alu_result", alu_result, 32'd1);
    @(negedge clk); funct = 6'b100101; step("or");
    check("or_lit", "alu_result", alu_result, 32'hFFFF_FFFF);
    @(negedge clk); funct = 6'b101010; step("slt");
    check("slt_lit", "alu_result", alu_result, 32'd1);
    @(negedge clk); funct = 6'b000000; step("nop");
    check("nop_lit", "zero", {31'd0, zero}, 32'd1);

    // Mid-stream reset clears immediately, without waiting for a clock edge
    @(negedge clk); rand_inputs(); m_ctl = 3'b111; wb_ctl = 2'b11; step("pre_rst");
    #2 rst_n = 0;
    #1 expect_zero("midreset");
    @(posedge clk); #1 expect_zero("midreset_held");
    // Release between edges: next edge captures current inputs
    @(negedge clk); rand_inputs(); #1 rst_n = 1;
    step("release");

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_inputs();
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
